// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-unit constants for the sequencer and the microinstruction decoder.
// Provides phase indices, opcode values, the one-hot phase encoding and a phase legality helper.
package cpu_ctrl_pkg;

    localparam int PH_FETCH = 0;
    localparam int PH_PC    = 1;
    localparam int PH_EXA   = 2;
    localparam int PH_EXB   = 3;

    localparam logic [3:0] NOP  = 4'h0;
    localparam logic [3:0] ADD  = 4'h1;
    localparam logic [3:0] SUB  = 4'h2;
    localparam logic [3:0] OUT  = 4'h3;
    localparam logic [3:0] IN   = 4'h4;
    localparam logic [3:0] LOAD = 4'h5;
    localparam logic [3:0] HLT  = 4'hF;

    typedef enum logic [3:0] {
        P0 = 4'b0001,
        P1 = 4'b0010,
        P2 = 4'b0100,
        P3 = 4'b1000
    } phase_t;

    function automatic logic phase_legal(input logic [3:0] p);
        return $onehot(p);
    endfunction

endpackage

// File: rtl/step_edge_detect.sv
// step_edge_detect: registered rising-edge detector for the single-step switch.
// Ports: clk, rst_n (async active-low), step (level), clear (discard a pending edge),
//        step_edge (one-cycle registered pulse after a 0->1 transition of step).
module step_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic clear,
    output logic step_edge
);

    logic step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= 1'b0;
            step_edge <= 1'b0;
        end else begin
            step_q    <= step;
            step_edge <= step & ~step_q & ~clear;
        end
    end

endmodule

// File: rtl/phase_ring_sequencer.sv
// phase_ring_sequencer: one-hot fetch/execute phase ring with instruction register, single-step and halt.
// Ports: Clk, ResetN (async active-low), Run (free-run), Step (single-step level), Resume (clear halt),
//        LoadInstr (IR capture enable in P0), BusIn (data bus), Phase0..Phase3 (one-hot phase),
//        Instr0..Instr3 (IR[4]..IR[7]), Operand (IR[3:0]), StepAck (step-mode advance pulse), Halted.
module phase_ring_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         IR_WIDTH    = 8,
    parameter logic [3:0] OPCODE_HALT = HLT
) (
    input  logic                Clk,
    input  logic                ResetN,
    input  logic                Run,
    input  logic                Step,
    input  logic                Resume,
    input  logic                LoadInstr,
    input  logic [IR_WIDTH-1:0] BusIn,
    output logic                Phase0,
    output logic                Phase1,
    output logic                Phase2,
    output logic                Phase3,
    output logic                Instr0,
    output logic                Instr1,
    output logic                Instr2,
    output logic                Instr3,
    output logic [3:0]          Operand,
    output logic                StepAck,
    output logic                Halted
);

    phase_t              phase, phase_next;
    logic [IR_WIDTH-1:0] ir, ir_next;
    logic                halted, halted_next;
    logic                step_ack, step_ack_next;
    logic                step_edge;
    logic                adv;
    logic                resume_hit;

    // A resume that actually clears a halt also swallows any step edge arriving with it.
    assign resume_hit = halted & Resume;
    assign adv        = ~halted & (Run | step_edge);

    step_edge_detect u_step_edge (
        .clk       (Clk),
        .rst_n     (ResetN),
        .step      (Step),
        .clear     (resume_hit),
        .step_edge (step_edge)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            phase    <= P0;
            ir       <= '0;
            halted   <= 1'b0;
            step_ack <= 1'b0;
        end else begin
            phase    <= phase_next;
            ir       <= ir_next;
            halted   <= halted_next;
            step_ack <= step_ack_next;
        end
    end

    always_comb begin
        phase_next    = phase;
        ir_next       = ir;
        halted_next   = halted;
        step_ack_next = 1'b0;
        if (!phase_legal(phase)) begin
            phase_next = P0;
        end else if (resume_hit) begin
            halted_next = 1'b0;
            phase_next  = P0;
        end else if (adv) begin
            // Without Run, an advance can only come from a step edge.
            step_ack_next = ~Run;
            case (phase)
                P0: begin
                    phase_next = P1;
                    ir_next    = LoadInstr ? BusIn : ir;
                end
                P1: begin
                    // Halt still moves into P2, where the decoder idles on the halt opcode.
                    phase_next  = P2;
                    halted_next = (ir[7:4] == OPCODE_HALT);
                end
                P2:      phase_next = P3;
                P3:      phase_next = P0;
                default: phase_next = P0;
            endcase
        end
    end

    assign Phase0  = phase[PH_FETCH];
    assign Phase1  = phase[PH_PC];
    assign Phase2  = phase[PH_EXA];
    assign Phase3  = phase[PH_EXB];
    assign Instr0  = ir[4];
    assign Instr1  = ir[5];
    assign Instr2  = ir[6];
    assign Instr3  = ir[7];
    assign Operand = ir[3:0];
    assign StepAck = step_ack;
    assign Halted  = halted;

endmodule

// File: tb/tb_phase_ring_sequencer.sv
// tb_phase_ring_sequencer: self-checking bench with vector table, corner sequences and random stimulus.
module tb_phase_ring_sequencer;

    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       Run = 1'b0;
    logic       Step = 1'b0;
    logic       Resume = 1'b0;
    logic       LoadInstr = 1'b0;
    logic [7:0] BusIn = 8'h00;
    logic       Phase0, Phase1, Phase2, Phase3;
    logic       Instr0, Instr1, Instr2, Instr3;
    logic [3:0] Operand;
    logic       StepAck, Halted;

    always #5 Clk = ~Clk;

    phase_ring_sequencer dut (
        .Clk(Clk), .ResetN(ResetN), .Run(Run), .Step(Step), .Resume(Resume),
        .LoadInstr(LoadInstr), .BusIn(BusIn),
        .Phase0(Phase0), .Phase1(Phase1), .Phase2(Phase2), .Phase3(Phase3),
        .Instr0(Instr0), .Instr1(Instr1), .Instr2(Instr2), .Instr3(Instr3),
        .Operand(Operand), .StepAck(StepAck), .Halted(Halted)
    );

    int total = 0;
    int bad = 0;

    int         m_ph = 0;
    logic [7:0] m_ir = 8'h00;
    logic       m_halt = 1'b0;
    logic       m_prev = 1'b0;
    logic       m_pend = 1'b0;
    logic       m_ack = 1'b0;

    typedef struct {
        logic       run;
        logic       step;
        logic       load;
        logic [7:0] bus;
        int         ph;
        logic [7:0] ir;
        logic       ack;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [13:0] exp_vec(int ph, logic [7:0] ir, logic ack, logic halt);
        logic [3:0] oh;
        oh = 4'b0001 << ph;
        return {oh, ir, ack, halt};
    endfunction

    task automatic check(string name, logic [13:0] want);
        logic [13:0] got;
        got = {Phase3, Phase2, Phase1, Phase0, Instr3, Instr2, Instr1, Instr0, Operand, StepAck, Halted};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (phase3..0,instr3..0,operand,stepack,halted)", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_ir = 8'h00; m_halt = 1'b0; m_prev = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
    endtask

    // One clock: advance the reference model from the current inputs, then compare on the falling edge.
    task automatic tick();
        int         ph;
        logic [7:0] ir;
        logic       halt, pend, ack, adv, clr, prev;
        adv  = !m_halt && (Run || m_pend);
        clr  = m_halt && Resume;
        ph   = m_ph;
        ir   = m_ir;
        halt = m_halt;
        ack  = 1'b0;
        if (clr) begin
            halt = 1'b0;
            ph   = 0;
        end else if (adv) begin
            ack = !Run;
            if (m_ph == 0 && LoadInstr) ir = BusIn;
            if (m_ph == 1 && m_ir[7:4] == 4'hF) halt = 1'b1;
            ph = (m_ph + 1) % 4;
        end
        pend = Step && !m_prev && !clr;
        prev = Step;
        @(posedge Clk);
        m_ph = ph; m_ir = ir; m_halt = halt; m_pend = pend; m_prev = prev; m_ack = ack;
        @(negedge Clk);
        check("model", exp_vec(m_ph, m_ir, m_ack, m_halt));
    endtask

    task automatic goto_p0();
        Run = 1'b1; Step = 1'b0; Resume = 1'b0; LoadInstr = 1'b0;
        for (int k = 0; k < 4 && m_ph != 0; k++) tick();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h1A, 1, 8'h1A, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h55, 2, 8'h1A, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h77, 3, 8'h1A, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 0, 8'h1A, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h44, 1, 8'h1A, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h3C, 2, 8'h1A, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3, 8'h1A, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h1A, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h1A, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h1A, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h1A, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h1A, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h1A, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 8'h1A, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h1A, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 2, 8'h1A, 1'b1};

        model_reset();
        repeat (2) @(negedge Clk);
        check("reset", exp_vec(0, 8'h00, 1'b0, 1'b0));
        ResetN = 1'b1;

        for (int i = 0; i < 16; i++) begin
            Run = tbl[i].run; Step = tbl[i].step; LoadInstr = tbl[i].load; BusIn = tbl[i].bus;
            tick();
            check($sformatf("vec%0d", i), exp_vec(tbl[i].ph, tbl[i].ir, tbl[i].ack, 1'b0));
        end

        // Halt on opcode F, hold, resume, then a non-halt opcode runs normally.
        goto_p0();
        LoadInstr = 1'b1; BusIn = 8'hF0;
        tick();
        LoadInstr = 1'b0; BusIn = 8'h12;
        tick();
        check("halt_set", exp_vec(2, 8'hF0, 1'b0, 1'b1));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_hold", exp_vec(2, 8'hF0, 1'b0, 1'b1));
        end
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        check("resume", exp_vec(0, 8'hF0, 1'b0, 1'b0));
        LoadInstr = 1'b1; BusIn = 8'h7C;
        tick();
        LoadInstr = 1'b0;
        check("nohalt_load", exp_vec(1, 8'h7C, 1'b0, 1'b0));
        repeat (7) tick();
        check("nohalt_run", exp_vec(0, 8'h7C, 1'b0, 1'b0));

        // Asynchronous reset in the middle of P2.
        LoadInstr = 1'b1; BusIn = 8'h25;
        tick();
        LoadInstr = 1'b0;
        tick();
        check("pre_rst", exp_vec(2, 8'h25, 1'b0, 1'b0));
        #1 ResetN = 1'b0;
        #1 check("async_rst", exp_vec(0, 8'h00, 1'b0, 1'b0));
        model_reset();
        @(negedge Clk);
        check("rst_hold", exp_vec(0, 8'h00, 1'b0, 1'b0));
        #1 ResetN = 1'b1;
        tick();
        check("restart", exp_vec(1, 8'h00, 1'b0, 1'b0));

        // Resume and Step rising together while halted: resume wins, step is dropped.
        goto_p0();
        LoadInstr = 1'b1; BusIn = 8'hF3;
        tick();
        LoadInstr = 1'b0;
        tick();
        Run = 1'b0;
        tick();
        check("halt2", exp_vec(2, 8'hF3, 1'b0, 1'b1));
        Resume = 1'b1; Step = 1'b1;
        tick();
        Resume = 1'b0;
        check("res_step", exp_vec(0, 8'hF3, 1'b0, 1'b0));
        tick();
        check("res_step_drop", exp_vec(0, 8'hF3, 1'b0, 1'b0));
        Step = 1'b0;
        tick();

        for (int i = 0; i < 400; i++) begin
            Run       = ($urandom_range(0, 9) < 4);
            Step      = 1'($urandom_range(0, 1));
            Resume    = ($urandom_range(0, 9) == 0);
            LoadInstr = 1'($urandom_range(0, 1));
            BusIn     = ($urandom_range(0, 3) == 0) ? {4'hF, 4'($urandom)} : 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
